// File: rtl/booth4_mul_seq.sv
// booth4_mul_seq
// ---------------
// Multi-cycle controller that forms a (4*NIB)x(4*NIB) unsigned product by
// time-sharing one external combinational 4x4 unsigned multiplier (radix-4
// Booth partial products plus a 9-bit ripple adder). Each MUL cycle drives
// one nibble pair, then adds the returned 8-bit product into the accumulator,
// shifted into place.
//
// Optional feature (macro BOOTH4_MUL_CHECK_EN):
//   When defined, every MUL cycle compares mul_p with a behavioural
//   mul_a*mul_b. Any mismatch sets the sticky err flag on the next edge.
//   err stays set until reset. Accumulation always uses mul_p.
//   When undefined, err is tied low and no check logic exists.
//
// Handshakes (both sides use plain valid/ready):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The producer holds in_a/in_b with in_valid until the transfer.
//   out_p is held stable while out_valid=1 and out_ready=0.
//   in_ready is high only in IDLE, so no operands are taken in DONE.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_a, in_b are W=4*NIB unsigned
//   mul_a, mul_b        nibbles to the shared multiplier (0 outside MUL)
//   mul_p               9-bit combinational product from the multiplier
//   out_valid/out_ready product handshake; out_p is 8*NIB bits
//   busy                high in MUL or DONE
//   err                 sticky datapath-check flag
//   dbg_state           current FSM state (IDLE=0, MUL=1, DONE=2)

module booth4_mul_seq #(
    parameter int NIB = 2  // nibbles per operand, legal range 1..4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*NIB-1:0]   in_a,
    input  logic [4*NIB-1:0]   in_b,
    output logic [3:0]         mul_a,
    output logic [3:0]         mul_b,
    input  logic [8:0]         mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*NIB-1:0]   out_p,
    output logic               busy,
    output logic               err,
    output logic [1:0]         dbg_state
);

    localparam int W  = 4 * NIB;
    localparam int PW = 8 * NIB;
    localparam logic [3:0] K_LAST = 4'(NIB * NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [W-1:0]    a_q, b_q;
    logic [PW-1:0]   acc;
    logic [3:0]      k;
    logic [2:0]      i_idx, j_idx;
    logic [3:0]      shift_nib;
    logic [3:0]      nib_a, nib_b;
    logic [PW-1:0]   term;
    logic            accept;

    // Step k walks the nibbles of a fastest: i = k mod NIB, j = k div NIB.
    assign i_idx     = 3'(k % 4'(NIB));
    assign j_idx     = 3'(k / 4'(NIB));
    assign nib_a     = 4'(a_q >> {i_idx, 2'b00});
    assign nib_b     = 4'(b_q >> {j_idx, 2'b00});
    assign shift_nib = {1'b0, i_idx} + {1'b0, j_idx};
    // Bit 8 of mul_p never contributes to the sum.
    assign term      = PW'(mul_p[7:0]) << {shift_nib, 2'b00};

    assign accept    = (state == IDLE) && in_valid;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        mul_a      = 4'h0;
        mul_b      = 4'h0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = MUL;
            end
            MUL: begin
                busy  = 1'b1;
                mul_a = nib_a;
                mul_b = nib_b;
                if (k == K_LAST) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state = state;

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            k   <= '0;
        end else if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
            acc <= '0;
            k   <= '0;
        end else if (state == MUL) begin
            // The multiplier is combinational: its product for the nibbles
            // driven this cycle is taken on this same edge.
            acc <= acc + term;
            k   <= (k == K_LAST) ? 4'h0 : k + 4'h1;
        end
    end

    // acc is only cleared on acceptance, so the last product stays visible
    // in IDLE.
    assign out_p = acc;

`ifdef BOOTH4_MUL_CHECK_EN
    logic [7:0] ref_p;
    logic       err_q;

    assign ref_p = 8'(mul_a) * 8'(mul_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state == MUL) && (mul_p != {1'b0, ref_p})) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_mul_p8;

    assign unused_mul_p8 = mul_p[8];
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_booth4_mul_seq.sv
// tb_booth4_mul_seq
// -----------------
// Directed test of booth4_mul_seq with NIB=2. The bench models the shared
// 4x4 multiplier behaviourally and, when BOOTH4_MUL_CHECK_EN is defined,
// corrupts the (2,4) nibble product of one operation.

module tb_booth4_mul_seq;

    localparam int NIB = 2;

`ifdef BOOTH4_MUL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a, in_b;
    logic [3:0]  mul_a, mul_b;
    logic [8:0]  mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;
    logic        err;
    logic [1:0]  dbg_state;
    logic        inject;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];

    // ---------------- Clock ----------------
    always #5 clk = ~clk;

    // Behavioural shared multiplier with optional fault on the (2,4) pair.
    assign mul_p = (inject && mul_a == 4'h2 && mul_b == 4'h4) ? 9'h000
                                                               : {1'b0, 8'(mul_a) * 8'(mul_b)};

    booth4_mul_seq #(.NIB(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- Checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_p"},     32'(out_p),     32'h0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_in_ready"},  32'(in_ready),  32'h1);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_mul_a"},     32'(mul_a),     32'h0);
        check({tag, "_mul_b"},     32'(mul_b),     32'h0);
        check({tag, "_err"},       32'(err),       32'h0);
    endtask

    // One full operation. pairs holds the expected (mul_a,mul_b) nibbles of
    // steps 0..3, step 0 in the top byte. hold = cycles out_ready stays low
    // in DONE while in_valid is pulsed.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [31:0] pairs, input logic [15:0] exp_p,
                          input logic exp_err, input int hold);
        logic [15:0] want;
        check("idle_in_ready", 32'(in_ready), 32'h1);
        check("idle_busy",     32'(busy),     32'h0);
        out_ready = (hold == 0);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_q.push_back(exp_p);
        check("acc_cleared", 32'(out_p), 32'h0);
        for (int s = 0; s < 4; s++) begin
            logic [7:0] pr;
            pr = 8'(pairs >> (8 * (3 - s)));
            check("mul_a",         32'(mul_a),     32'(pr[7:4]));
            check("mul_b",         32'(mul_b),     32'(pr[3:0]));
            check("mul_in_ready",  32'(in_ready),  32'h0);
            check("mul_out_valid", 32'(out_valid), 32'h0);
            check("mul_busy",      32'(busy),      32'h1);
            tick();
        end
        want = exp_q.pop_front();
        check("done_out_valid", 32'(out_valid), 32'h1);
        check("done_out_p",     32'(out_p),     32'(want));
        check("done_in_ready",  32'(in_ready),  32'h0);
        check("done_mul_a",     32'(mul_a),     32'h0);
        check("done_mul_b",     32'(mul_b),     32'h0);
        check("done_err",       32'(err),       32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            in_valid = ~h[0];
            in_a     = 8'h77;
            in_b     = 8'h99;
            tick();
            check("hold_out_valid", 32'(out_valid), 32'h1);
            check("hold_out_p",     32'(out_p),     32'(want));
            check("hold_in_ready",  32'(in_ready),  32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("back_idle_out_valid", 32'(out_valid), 32'h0);
        check("back_idle_in_ready",  32'(in_ready),  32'h1);
        check("back_idle_busy",      32'(busy),      32'h0);
        check("back_idle_out_p",     32'(out_p),     32'(want));
    endtask

    // ---------------- Watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = 8'h00;
        in_b      = 8'h00;
        inject    = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 0xFF * 0xFF
        run_op(8'hFF, 8'hFF, 32'hFF_FF_FF_FF, 16'hFE01, 1'b0, 0);

        // 0x12 * 0x34; with the check built, the (2,4) product is forced to 0
`ifdef BOOTH4_MUL_CHECK_EN
        inject = 1'b1;
        run_op(8'h12, 8'h34, 32'h24_14_23_13, 16'h03A0, 1'b1, 0);
        inject = 1'b0;
`else
        run_op(8'h12, 8'h34, 32'h24_14_23_13, 16'h03A8, 1'b0, 0);
`endif

        // Zero operand, then back-to-back identity-like case
        run_op(8'h00, 8'hAB, 32'h0B_0B_0A_0A, 16'h0000, EXP_ERR, 0);
        run_op(8'hAB, 8'h01, 32'hB1_A1_B0_A0, 16'h00AB, EXP_ERR, 0);

        // Back-pressure: out_ready low for 5 cycles in DONE
        run_op(8'h5A, 8'hC3, 32'hA3_53_AC_5C, 16'h448E, EXP_ERR, 5);

        // Reset in the middle of an operation at step k=2
        in_a     = 8'h12;
        in_b     = 8'h34;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midop_mul_a", 32'(mul_a), 32'h2);
        check("midop_mul_b", 32'(mul_b), 32'h3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("post_reset_out_valid", 32'(out_valid), 32'h0);
            check("post_reset_in_ready",  32'(in_ready),  32'h1);
        end

        // Fresh operation after reset; err was cleared by the reset
        run_op(8'h12, 8'h34, 32'h24_14_23_13, 16'h03A8, 1'b0, 0);
        check("final_err", 32'(err), 32'h0);
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/booth4_mul_seq.md
Name: booth4_mul_seq

Overview:
- Multi-cycle controller that computes wide unsigned products by time-sharing one combinational 4x4 unsigned radix-4 Booth multiplier.
- The multiplier is the partial-product generator plus the final 9-bit carry-ripple adder stage.
- The controller splits each operand into nibbles, drives one nibble pair per cycle into the shared multiplier, and shifts and accumulates the results.
- It sits between a valid/ready producer and consumer, upstream of the multiplier datapath instance.

Parameters:
- NIB, 2: nibbles per operand. Operand width W = 4*NIB. Product width 8*NIB. Legal range 1..4.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: controller can accept operands.
- in_a, input, W: multiplicand, unsigned.
- in_b, input, W: multiplier, unsigned.
- mul_a, output, 4: nibble driven to the shared 4x4 multiplier operand A.
- mul_b, output, 4: nibble driven to the shared 4x4 multiplier operand B.
- mul_p, input, 9: combinational product returned by the shared multiplier. Bit 8 is 0 for legal results.
- out_valid, output, 1: product valid.
- out_ready, input, 1: consumer accepts product.
- out_p, output, 8*NIB: product.
- busy, output, 1: high in MUL or DONE.
- err, output, 1: sticky datapath-check flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE; step counter k=0; accumulator=0.
  - Output values in reset: out_p=0, out_valid=0, in_ready=1, busy=0, mul_a=0, mul_b=0, err=0.
- Reset mid-operation aborts the operation: no out_valid is produced and the accumulator is cleared.
- State machine:
  - IDLE: in_ready=1.
    - On in_valid & in_ready: register in_a and in_b, clear the accumulator, set k=0, go to MUL.
  - MUL: in_ready=0.
    - Drive mul_a = a nibble i = k mod NIB, and mul_b = b nibble j = k div NIB.
    - Each edge: acc <= acc + (mul_p[7:0] << 4*(i+j)); k <= k+1.
    - After step k = NIB*NIB-1: go to DONE.
  - DONE: out_valid=1, in_ready=0.
    - out_p = acc, held stable while out_ready=0.
    - On out_valid & out_ready: go to IDLE.
- mul_a and mul_b are 0 outside MUL.
- mul_p is sampled on the same edge that its nibbles are driven, so the multiplier is treated as single-cycle combinational.
- Latency: out_valid rises NIB*NIB edges after the acceptance edge (4 for NIB=2).
- Minimum issue interval: NIB*NIB+2 cycles. There is no acceptance in DONE, even when out_ready=1.
- in_valid while busy is ignored. The producer must hold in_a and in_b with in_valid until handshake.
- Accumulator width is 8*NIB; the true result never overflows and no wrap occurs. mul_p[8] is excluded from accumulation.
- out_p keeps its last value in IDLE and is cleared only on acceptance of a new operand pair or on reset.

Optional Feature:
- Macro: BOOTH4_MUL_CHECK_EN.
- When defined:
  - Each MUL cycle compares mul_p against a behavioural mul_a*mul_b, zero-extended to 9 bits.
  - Any mismatch sets err on the next edge. err remains set until reset.
  - Accumulation uses mul_p regardless of the check result.
- When undefined: err is tied to 0 and no check logic is built.

Test Plan:
- NIB=2, in_a=0xFF, in_b=0xFF, out_ready=1 -> out_valid 4 edges after acceptance, out_p=0xFE01; mul_a/mul_b sequence (F,F) x4.
- in_a=0x12, in_b=0x34 -> mul pairs (2,4),(1,4),(2,3),(1,3); out_p=0x03A8.
- in_a=0x00, in_b=0xAB -> out_p=0x0000; then in_a=0xAB, in_b=0x01 back-to-back -> out_p=0x00AB; in_ready low during MUL and DONE.
- out_ready held 0 for 5 cycles in DONE -> out_valid and out_p stable, in_valid pulses ignored; released -> IDLE next edge, in_ready=1.
- Assert rst_n=0 at MUL step k=2 -> all outputs at reset values immediately; after release no out_valid until a new acceptance.
- BOOTH4_MUL_CHECK_EN defined, bench forces mul_p=0x00 when mul_a=2 and mul_b=4 (in_a=0x12, in_b=0x34) -> err=1 next edge and stays high through the next operation; undefined -> err=0 always.
